// File: rtl/debounce_multi.sv
// N-channel switch debouncer with rise/fall strobes and auto-repeat; o_state settles 2+MAX edges after a clean step.
// All outputs registered; no flow control, every channel samples its switch on every i_clk edge.
module debounce_multi #(
    parameter int CHANNELS     = 4,
    parameter int MAX          = 250000,
    parameter int REPEAT_DELAY = 5000000,
    parameter int REPEAT_RATE  = 1250000,
    localparam int CNT_W       = $clog2(MAX + 1),
    localparam int RPT_MAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE,
    localparam int RPT_W       = $clog2(RPT_MAX + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_switch,
    input  logic                i_repeat_en,
    output logic [CHANNELS-1:0] o_state,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_repeat
);

    typedef enum logic {
        PH_DELAY = 1'b0,
        PH_RATE  = 1'b1
    } phase_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX - 1);
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] sync_s;

    logic [CNT_W-1:0] cnt         [CHANNELS];
    logic [CNT_W-1:0] cnt_nxt     [CHANNELS];
    logic [RPT_W-1:0] rpt_cnt     [CHANNELS];
    logic [RPT_W-1:0] rpt_cnt_nxt [CHANNELS];
    phase_t           phase       [CHANNELS];
    phase_t           phase_nxt   [CHANNELS];

    logic [CHANNELS-1:0] state_nxt;
    logic [CHANNELS-1:0] rise_nxt;
    logic [CHANNELS-1:0] fall_nxt;
    logic [CHANNELS-1:0] repeat_nxt;

    always_comb begin
        state_nxt  = o_state;
        rise_nxt   = '0;
        fall_nxt   = '0;
        repeat_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i]     = '0;
            rpt_cnt_nxt[i] = '0;
            phase_nxt[i]   = PH_DELAY;

            // Any cycle where the synchronised input agrees with o_state restarts the count.
            if (sync_s[i] != o_state[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    state_nxt[i] = sync_s[i];
                    rise_nxt[i]  = sync_s[i];
                    fall_nxt[i]  = ~sync_s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end

            // A fall this cycle wins over a due repeat pulse.
            if (rise_nxt[i]) begin
                repeat_nxt[i] = 1'b1;
            end else if (o_state[i] && !fall_nxt[i] && i_repeat_en) begin
                phase_nxt[i] = phase[i];
                if (phase[i] == PH_DELAY && rpt_cnt[i] == DLY_LAST) begin
                    repeat_nxt[i] = 1'b1;
                    phase_nxt[i]  = PH_RATE;
                end else if (phase[i] == PH_RATE && rpt_cnt[i] == RATE_LAST) begin
                    repeat_nxt[i] = 1'b1;
                end else begin
                    rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_meta <= '0;
            sync_s    <= '0;
            o_state   <= '0;
            o_rise    <= '0;
            o_fall    <= '0;
            o_repeat  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]     <= '0;
                rpt_cnt[i] <= '0;
                phase[i]   <= PH_DELAY;
            end
        end else begin
            sync_meta <= i_switch;
            sync_s    <= sync_meta;
            o_state   <= state_nxt;
            o_rise    <= rise_nxt;
            o_fall    <= fall_nxt;
            o_repeat  <= repeat_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]     <= cnt_nxt[i];
                rpt_cnt[i] <= rpt_cnt_nxt[i];
                phase[i]   <= phase_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed timing checks plus randomized bouncing inputs against a window/arithmetic model.
module tb_debounce_multi;

    localparam int CH  = 2;
    localparam int MAX = 4;
    localparam int RD  = 8;
    localparam int RR  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] sw  = '0;
    logic          en  = 1'b0;
    logic [CH-1:0] o_state, o_rise, o_fall, o_repeat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS(CH), .MAX(MAX), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_switch(sw), .i_repeat_en(en),
        .o_state(o_state), .o_rise(o_rise), .o_fall(o_fall), .o_repeat(o_repeat)
    );

    // Model: input seen by the debouncer is the raw input two edges back; the level flips once
    // the last MAX seen values all disagree with it. Repeats follow from the count of held, enabled edges.
    logic [CH-1:0] in_q [$];
    logic [CH-1:0] s_q  [$];
    logic [CH-1:0] m_state = '0, m_rise = '0, m_fall = '0, m_rpt = '0;
    int            run [CH];

    task automatic model_step();
        logic [CH-1:0] s;
        logic [CH-1:0] old_st;
        bit            flip;
        if (rst) begin
            in_q.delete();
            s_q.delete();
            m_state = '0; m_rise = '0; m_fall = '0; m_rpt = '0;
            for (int c = 0; c < CH; c++) run[c] = 0;
            return;
        end
        in_q.push_back(sw);
        if (in_q.size() > 3) void'(in_q.pop_front());
        s = (in_q.size() == 3) ? in_q[0] : '0;
        s_q.push_back(s);
        if (s_q.size() > MAX) void'(s_q.pop_front());
        old_st = m_state;
        m_rise = '0; m_fall = '0; m_rpt = '0;
        for (int c = 0; c < CH; c++) begin
            flip = (s_q.size() == MAX);
            for (int k = 0; k < s_q.size(); k++)
                if (s_q[k][c] == old_st[c]) flip = 0;
            if (flip) begin
                m_state[c] = ~old_st[c];
                m_rise[c]  = m_state[c];
                m_fall[c]  = old_st[c];
            end
            if (m_rise[c]) begin
                m_rpt[c] = 1'b1;
                run[c]   = 0;
            end else if (old_st[c] && m_state[c] && en) begin
                run[c]++;
                m_rpt[c] = (run[c] == RD) || (run[c] > RD && (run[c] - RD) % RR == 0);
            end else begin
                run[c] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        chk("model_state",  int'(o_state),  int'(m_state));
        chk("model_rise",   int'(o_rise),   int'(m_rise));
        chk("model_fall",   int'(o_fall),   int'(m_fall));
        chk("model_repeat", int'(o_repeat), int'(m_rpt));
    end

    // sel: 0 rise, 1 fall, 2 repeat. n = edges until the strobe, -1 if it never came.
    task automatic wait_strobe(input int sel, input int ch, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            n++;
            if ((sel == 0 && o_rise[ch]) || (sel == 1 && o_fall[ch]) || (sel == 2 && o_repeat[ch]))
                return;
        end
        n = -1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_state"},  int'(o_state),  0);
        chk({tag, "_rise"},   int'(o_rise),   0);
        chk({tag, "_fall"},   int'(o_fall),   0);
        chk({tag, "_repeat"}, int'(o_repeat), 0);
    endtask

    initial begin
        int n;
        int hold [CH];
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hold [CH];

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Single channel step
        @(negedge clk); sw = 2'b01;
        wait_strobe(0, 0, n);
        chk("step_rise_latency", n, 6);
        chk("step_repeat_with_rise", int'(o_repeat[0]), 1);
        chk("step_state", int'(o_state), 1);
        @(posedge clk); #1;
        chk("step_rise_one_cycle", int'(o_rise[0]), 0);
        chk("step_repeat_one_cycle", int'(o_repeat[0]), 0);

        // Back low, then bounce
        @(negedge clk); sw = 2'b00;
        wait_strobe(1, 0, n);
        chk("ch0_fall_latency", n, 6);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); sw[0] = (k % 2 == 0);
        end
        @(negedge clk); sw[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("bounce_no_change", int'(o_state), 0);
        repeat (3) begin @(negedge clk); sw[0] = 1'b1; end
        @(negedge clk); sw[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("short_pulse_no_change", int'(o_state), 0);

        // Auto-repeat on channel 1
        en = 1'b1; sw = 2'b10;
        wait_strobe(2, 1, n);
        chk("rpt_first_at_rise", n, 6);
        chk("rpt_rise_same_cycle", int'(o_rise[1]), 1);
        wait_strobe(2, 1, n);
        chk("rpt_delay", n, RD);
        wait_strobe(2, 1, n);
        chk("rpt_rate_1", n, RR);
        wait_strobe(2, 1, n);
        chk("rpt_rate_2", n, RR);
        @(negedge clk); en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_strobe(2, 1, n);
        chk("rpt_reenable_delay", n, RD);

        // Release timed so the fall lands on a due repeat
        @(negedge clk); sw[1] = 1'b0;
        wait_strobe(1, 1, n);
        chk("release_fall_latency", n, 6);
        chk("release_no_repeat_in_fall", int'(o_repeat[1]), 0);
        repeat (12) @(negedge clk);
        chk("release_state", int'(o_state), 0);

        // Simultaneous steps
        sw = 2'b11;
        wait_strobe(0, 0, n);
        chk("simul_rise_latency", n, 6);
        chk("simul_rise_both", int'(o_rise), 3);
        @(negedge clk); sw = 2'b00;
        wait_strobe(1, 0, n);
        chk("simul_fall_latency", n, 6);
        chk("simul_fall_both", int'(o_fall), 3);

        // Async reset while held and repeating
        @(negedge clk); sw = 2'b11;
        wait_strobe(0, 0, n);
        chk("held_rise_latency", n, 6);
        repeat (4) @(posedge clk);
        #4 rst = 1'b1;
        #1 chk_zero_outputs("async_rst_held");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_strobe(0, 0, n);
        chk("rise_after_release", n, 6);

        // Async reset mid-count
        @(negedge clk); sw = 2'b00;
        wait_strobe(1, 0, n);
        chk("fall_before_midcount", n, 6);
        @(negedge clk); sw = 2'b11;
        repeat (4) @(posedge clk);
        #4 rst = 1'b1;
        #1 chk_zero_outputs("async_rst_count");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_strobe(0, 1, n);
        chk("midcount_discarded", n, 6);

        // Randomized bouncing, enable toggling and occasional resets
        for (int c = 0; c < CH; c++) hold[c] = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    sw[c]   = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                          : int'($urandom_range(1, 5));
                end
            end
            if ($urandom_range(0, 63) == 0) en = ~en;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 999) == 0) rst = 1'b1;
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
